// File: rtl/onehot_ring_pkg.sv
// Shared types and helpers for the one-hot ring checker and its decoder.
package onehot_ring_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } ring_chk_state_t;

  localparam int unsigned OH_MAX_W = 32;

  typedef struct packed {
    logic        legal;
    logic [31:0] index;
  } oh0_dec_t;

  // Ring order wraps 0 -> 1 -> ... -> n -> 0
  function automatic int unsigned succ_idx(input int unsigned i, input int unsigned n);
    return (i >= n) ? 0 : i + 1;
  endfunction

  function automatic oh0_dec_t oh0_decode(input logic [OH_MAX_W-1:0] code);
    oh0_dec_t r;
    r.legal = $onehot0(code);
    r.index = '0;
    for (int k = 0; k < OH_MAX_W; k++) begin
      if (code[k]) r.index = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_ring_decode.sv
// Combinational onehot0 decoder: all-zero -> 0, bit k set -> k+1.
module onehot_ring_decode #(
  parameter int N  = 3,
  parameter int IW = $clog2(N + 1)
) (
  input  logic [N-1:0]  code_i,
  output logic          legal_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    legal_o = $onehot0(code_i);
    idx_o   = '0;
    // Index is only meaningful when legal_o is set
    for (int k = 0; k < N; k++) begin
      if (code_i[k]) idx_o = IW'(k + 1);
    end
  end

endmodule

// File: rtl/onehot_ring_checker.sv
// Monitor for the one-hot ring sequencer: decodes strobed samples, checks
// legality and ordering, and keeps error and lap statistics.
//
//   state | meaning
//   HUNT  | waiting for the first legal sample to lock onto
//   LOCK  | tracking the ring, each sample checked against succ(last)
module onehot_ring_checker
  import onehot_ring_pkg::*;
#(
  parameter int N     = 3,
  parameter int ERR_W = 8,
  parameter int LAP_W = 16,
  localparam int IW   = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [N-1:0]     state,
  output logic [IW-1:0]    idx,
  output logic             idx_vld,
  output logic             locked,
  output logic             code_err,
  output logic             seq_err,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [LAP_W-1:0] lap_cnt
);

  ring_chk_state_t fsm_q;
  logic [IW-1:0]    idx_q, last_q;
  logic             idx_vld_q, code_err_q, seq_err_q, err_sticky_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [LAP_W-1:0] lap_cnt_q;

  logic             legal;
  logic [IW-1:0]    dec_idx;
  logic [IW-1:0]    succ_d;

  onehot_ring_decode #(.N(N), .IW(IW)) u_dec (
    .code_i  (state),
    .legal_o (legal),
    .idx_o   (dec_idx)
  );

  assign succ_d    = IW'(succ_idx(32'(last_q), N));
  assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= HUNT;
      idx_q        <= '0;
      last_q       <= '0;
      idx_vld_q    <= 1'b0;
      code_err_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      lap_cnt_q    <= '0;
    end else begin
      idx_vld_q  <= 1'b0;
      code_err_q <= 1'b0;
      seq_err_q  <= 1'b0;
      if (vld) begin
        if (!legal) begin
          // Illegal code always drops lock; idx and last hold
          code_err_q   <= 1'b1;
          err_sticky_q <= 1'b1;
          err_cnt_q    <= err_cnt_d;
          fsm_q        <= HUNT;
        end else begin
          idx_q     <= dec_idx;
          last_q    <= dec_idx;
          idx_vld_q <= 1'b1;
          if (fsm_q == HUNT) begin
            fsm_q <= LOCK;
          end else if (dec_idx == succ_d) begin
            if (last_q == IW'(N) && dec_idx == '0) lap_cnt_q <= lap_cnt_q + 1'b1;
          end else begin
            // Out-of-order but legal: resync to the observed position
            seq_err_q    <= 1'b1;
            err_sticky_q <= 1'b1;
            err_cnt_q    <= err_cnt_d;
          end
        end
      end
    end
  end

  assign idx        = idx_q;
  assign idx_vld    = idx_vld_q;
  assign locked     = (fsm_q == LOCK);
  assign code_err   = code_err_q;
  assign seq_err    = seq_err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign lap_cnt    = lap_cnt_q;

endmodule

// File: tb/tb_onehot_ring_checker.sv
// Directed-vector bench with an expectation queue drained by a monitor.
module tb_onehot_ring_checker;

  localparam int N  = 3;
  localparam int IW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [2:0] state_s = '0;

  logic [IW-1:0] idx_a, idx_b;
  logic          iv_a, iv_b, lk_a, lk_b, ce_a, ce_b, se_a, se_b, st_a, st_b;
  logic [7:0]    ec_a;
  logic [1:0]    ec_b;
  logic [15:0]   lap_a, lap_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int idx;
    int iv, lk, ce, se, st;
    int ec, ec2, lap;
  } exp_t;

  exp_t q[$];
  int   vec_id = 0;

  onehot_ring_checker #(.N(N), .ERR_W(8), .LAP_W(16)) dut_a (
    .clk(clk), .rst(rst), .vld(vld), .state(state_s),
    .idx(idx_a), .idx_vld(iv_a), .locked(lk_a), .code_err(ce_a), .seq_err(se_a),
    .err_sticky(st_a), .err_cnt(ec_a), .lap_cnt(lap_a)
  );

  onehot_ring_checker #(.N(N), .ERR_W(2), .LAP_W(16)) dut_b (
    .clk(clk), .rst(rst), .vld(vld), .state(state_s),
    .idx(idx_b), .idx_vld(iv_b), .locked(lk_b), .code_err(ce_b), .seq_err(se_b),
    .err_sticky(st_b), .err_cnt(ec_b), .lap_cnt(lap_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, id, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge
  task automatic step(input int r, input int v, input int s,
                      input int e_idx, input int e_iv, input int e_lk,
                      input int e_ce, input int e_se, input int e_st,
                      input int e_ec, input int e_ec2, input int e_lap);
    exp_t e;
    @(negedge clk);
    rst     = (r != 0);
    vld     = (v != 0);
    state_s = 3'(s);
    vec_id++;
    e.id = vec_id; e.idx = e_idx; e.iv = e_iv; e.lk = e_lk; e.ce = e_ce;
    e.se = e_se; e.st = e_st; e.ec = e_ec; e.ec2 = e_ec2; e.lap = e_lap;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("idx",      e.id, int'(idx_a), e.idx);
        chk("idx_vld",  e.id, int'(iv_a),  e.iv);
        chk("locked",   e.id, int'(lk_a),  e.lk);
        chk("code_err", e.id, int'(ce_a),  e.ce);
        chk("seq_err",  e.id, int'(se_a),  e.se);
        chk("sticky",   e.id, int'(st_a),  e.st);
        chk("err_cnt",  e.id, int'(ec_a),  e.ec);
        chk("lap_cnt",  e.id, int'(lap_a), e.lap);
        chk("b_idx",    e.id, int'(idx_b), e.idx);
        chk("b_idx_vld",e.id, int'(iv_b),  e.iv);
        chk("b_locked", e.id, int'(lk_b),  e.lk);
        chk("b_code",   e.id, int'(ce_b),  e.ce);
        chk("b_seq",    e.id, int'(se_b),  e.se);
        chk("b_sticky", e.id, int'(st_b),  e.st);
        chk("b_err_cnt",e.id, int'(ec_b),  e.ec2);
        chk("b_lap_cnt",e.id, int'(lap_b), e.lap);
      end
    end
  end

  initial begin : driver
    int budget;
    //    r v s      idx iv lk ce se st ec ec2 lap
    step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // full rotation plus one: lap after 100 -> 000
    step(0, 1, 3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3'b001, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3'b010, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3'b100, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 3'b001, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    // skip from 1 to 3
    step(0, 1, 3'b100, 3, 1, 1, 0, 1, 1, 1, 1, 1);
    step(0, 0, 3'b111, 3, 0, 1, 0, 0, 1, 1, 1, 1);
    // illegal drops lock, then relock at 2 without seq_err, then repeat 010
    step(0, 1, 3'b011, 3, 0, 0, 1, 0, 1, 2, 2, 1);
    step(0, 1, 3'b010, 2, 1, 1, 0, 0, 1, 2, 2, 1);
    step(0, 1, 3'b010, 2, 1, 1, 0, 1, 1, 3, 3, 1);
    // reset, then five illegal samples: 2-bit counter saturates
    step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3'b111, 0, 0, 0, 1, 0, 1, 1, 1, 0);
    step(0, 1, 3'b110, 0, 0, 0, 1, 0, 1, 2, 2, 0);
    step(0, 1, 3'b101, 0, 0, 0, 1, 0, 1, 3, 3, 0);
    step(0, 1, 3'b011, 0, 0, 0, 1, 0, 1, 4, 3, 0);
    step(0, 1, 3'b111, 0, 0, 0, 1, 0, 1, 5, 3, 0);
    // lock at 0 and run four laps, then stop at idx 2
    step(0, 1, 3'b000, 0, 1, 1, 0, 0, 1, 5, 3, 0);
    for (int lap = 1; lap <= 4; lap++) begin
      step(0, 1, 3'b001, 1, 1, 1, 0, 0, 1, 5, 3, lap - 1);
      step(0, 1, 3'b010, 2, 1, 1, 0, 0, 1, 5, 3, lap - 1);
      step(0, 1, 3'b100, 3, 1, 1, 0, 0, 1, 5, 3, lap - 1);
      step(0, 1, 3'b000, 0, 1, 1, 0, 0, 1, 5, 3, lap);
    end
    step(0, 1, 3'b001, 1, 1, 1, 0, 0, 1, 5, 3, 4);
    step(0, 1, 3'b010, 2, 1, 1, 0, 0, 1, 5, 3, 4);
    // mid-rotation reset clears everything; relock at 3
    step(1, 1, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 3'b100, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    // vld low with a wandering code: nothing moves
    for (int i = 0; i < 10; i++)
      step(0, 0, int'($urandom_range(0, 7)), 3, 0, 1, 0, 0, 0, 0, 0, 0);
    // wrap from 3 to 0 counts a lap after relock
    step(0, 1, 3'b000, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 0, 1);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
